// File: rtl/sram_phy_ctrl_pkg.sv
// Shared types and geometry for the three-chip async SRAM PHY.
package sram_phy_ctrl_pkg;

    localparam int unsigned NUM_CHIPS = 3;
    localparam int unsigned CHIP_W    = 16;
    localparam int unsigned BUS_W     = NUM_CHIPS * CHIP_W;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ACCESS,
        ST_RECOVER
    } state_t;

endpackage

// File: rtl/sram_phy_ctrl_chip_lane.sv
// One 16-bit SRAM chip lane: registered strobes and write-data driver for its slice.
module sram_chip_lane (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        active,
    input  logic        wr,
    input  logic        drive,
    input  logic [1:0]  be,
    input  logic [15:0] wdata,
    output logic        ce_n,
    output logic        oe_n,
    output logic        we_n,
    output logic        ub_n,
    output logic        lb_n,
    output logic        drv,
    output logic [15:0] data
);

    logic en;

    // A write lane with no byte enables stays fully deselected.
    assign en = active && (!wr || (|be));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ce_n <= 1'b1;
            oe_n <= 1'b1;
            we_n <= 1'b1;
            ub_n <= 1'b1;
            lb_n <= 1'b1;
            drv  <= 1'b0;
            data <= '0;
        end else begin
            ce_n <= ~en;
            oe_n <= ~(active && !wr);
            we_n <= ~(active && wr && (|be));
            ub_n <= ~(active && (!wr || be[1]));
            lb_n <= ~(active && (!wr || be[0]));
            drv  <= drive;
            data <= wdata;
        end
    end

endmodule

// File: rtl/sram_phy_ctrl.sv
// Single-beat 48-bit strobe/nak bus to async SRAM pin timing for three 16-bit chips.
module sram_phy_ctrl
    import sram_phy_ctrl_pkg::*;
#(
    parameter int unsigned ACC_CYCLES = 2,
    parameter int unsigned ADDR_W     = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_stb,
    input  logic [31:0]       wb_addr,
    input  logic [5:0]        wb_we,
    input  logic [47:0]       wb_din,
    output logic [47:0]       wb_dout,
    output logic              wb_nak,
    output logic [2:0]        sram_ce_n,
    output logic [2:0]        sram_oe_n,
    output logic [2:0]        sram_we_n,
    output logic [2:0]        sram_ub_n,
    output logic [2:0]        sram_lb_n,
    output logic [ADDR_W-1:0] sram_addr,
    inout  logic [47:0]       sram_data
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [5:0]        we_q;
    logic [47:0]       din_q;

    logic              accept;
    logic              last;
    logic [5:0]        we_sel;
    logic [47:0]       din_sel;
    logic              wr_sel;
    logic              active_next;
    logic              drive_next;
    logic [NUM_CHIPS-1:0] lane_drv;
    logic [15:0]       lane_data [NUM_CHIPS];
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{wb_addr[31:ADDR_W+2], wb_addr[1:0]};

    assign accept = (state == ST_IDLE) && wb_stb;
    assign last   = (cnt == CNT_W'(ACC_CYCLES - 1));

    // Lanes register their pins on the accept edge, so they see the live
    // request then and the latched copy for the rest of the access.
    assign we_sel      = accept ? wb_we  : we_q;
    assign din_sel     = accept ? wb_din : din_q;
    assign wr_sel      = |we_sel;
    assign active_next = accept || ((state == ST_ACCESS) && !last);
    assign drive_next  = wr_sel && (accept || (state == ST_ACCESS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            wb_nak    <= 1'b1;
            wb_dout   <= '0;
            sram_addr <= '0;
            cnt       <= '0;
            we_q      <= '0;
            din_q     <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    state  <= ST_IDLE;
                    wb_nak <= 1'b0;
                end
                ST_IDLE: begin
                    if (wb_stb) begin
                        state     <= ST_ACCESS;
                        wb_nak    <= 1'b1;
                        cnt       <= '0;
                        sram_addr <= wb_addr[ADDR_W+1:2];
                        we_q      <= wb_we;
                        din_q     <= wb_din;
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state <= ST_RECOVER;
                        if (we_q == '0) begin
                            wb_dout <= sram_data;
                        end
                    end
                end
                ST_RECOVER: begin
                    state  <= ST_IDLE;
                    wb_nak <= 1'b0;
                end
                default: begin
                    state  <= ST_INIT;
                    wb_nak <= 1'b1;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_CHIPS; k++) begin : g_lane
        sram_chip_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .active(active_next),
            .wr    (wr_sel),
            .drive (drive_next),
            .be    (we_sel[2*k+1:2*k]),
            .wdata (din_sel[16*k +: 16]),
            .ce_n  (sram_ce_n[k]),
            .oe_n  (sram_oe_n[k]),
            .we_n  (sram_we_n[k]),
            .ub_n  (sram_ub_n[k]),
            .lb_n  (sram_lb_n[k]),
            .drv   (lane_drv[k]),
            .data  (lane_data[k])
        );

        assign sram_data[16*k +: 16] = lane_drv[k] ? lane_data[k] : 'z;
    end

endmodule

// File: tb/tb_sram_phy_ctrl.sv
// Directed bench for sram_phy_ctrl with a behavioural three-chip async SRAM model.
module tb_sram_phy_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_stb;
    logic [31:0] wb_addr;
    logic [5:0]  wb_we;
    logic [47:0] wb_din;
    logic [47:0] wb_dout;
    logic        wb_nak;
    logic [2:0]  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic [19:0] sram_addr;
    wire  [47:0] sram_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_phy_ctrl #(.ACC_CYCLES(2), .ADDR_W(20)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_stb   (wb_stb),
        .wb_addr  (wb_addr),
        .wb_we    (wb_we),
        .wb_din   (wb_din),
        .wb_dout  (wb_dout),
        .wb_nak   (wb_nak),
        .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n),
        .sram_ub_n(sram_ub_n),
        .sram_lb_n(sram_lb_n),
        .sram_addr(sram_addr),
        .sram_data(sram_data)
    );

    // SRAM model: drives read data while any oe_n is low; probe drives zeros
    // so that an idle bus reads back as 0 only if the DUT is not driving it.
    logic [47:0] mem [256];
    logic        loaded = 1'b0;
    logic        probe  = 1'b0;
    logic [2:0]  prev_we_n = 3'b111;
    int          strobes = 0;

    assign sram_data = (probe || (sram_oe_n != 3'b111)) ?
                       (probe ? 48'h0 : mem[sram_addr[7:0]]) : 'z;

    always @(negedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] = '0;
            mem[8'h10] = 48'hAAAA_5555_0F0F;
            loaded = 1'b1;
        end
        for (int k = 0; k < 3; k++) begin
            if (!sram_we_n[k] && !sram_ce_n[k]) begin
                if (!sram_ub_n[k]) mem[sram_addr[7:0]][16*k+8 +: 8] = sram_data[16*k+8 +: 8];
                if (!sram_lb_n[k]) mem[sram_addr[7:0]][16*k +: 8]   = sram_data[16*k +: 8];
            end
            if (!sram_we_n[k] && prev_we_n[k]) strobes++;
        end
        prev_we_n = sram_we_n;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle(input string name);
        probe = 1'b1;
        #1;
        chk(name, 64'(sram_data), 64'h0);
        probe = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (wb_nak && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (wb_nak) begin
            errors++;
            $display("FAIL wait_idle: nak got 1 expected 0 within 20 cycles");
        end
    endtask

    function automatic logic [47:0] pat(input int i);
        return {16'(16'hB000 + i), 16'(16'hC000 + i), 16'(16'hD000 + i)};
    endfunction

    typedef struct {
        logic [5:0]  we;
        logic [31:0] addr;
        logic [47:0] din;
        logic [19:0] eaddr;
        logic [2:0]  ece, eoe, ewe, eub, elb;
        logic [47:0] edout;
    } vec_t;

    vec_t vt [9];

    task automatic run_vec(input vec_t v);
        logic wr;
        wr = (v.we != 6'h00);
        wait_idle();
        wb_stb  = 1'b1;
        wb_we   = v.we;
        wb_addr = v.addr;
        wb_din  = v.din;
        tick();
        wb_stb  = 1'b0;
        wb_we   = ~v.we;
        wb_din  = ~v.din;
        wb_addr = 32'hFFFF_FFFC;
        chk("acc0_nak",  64'(wb_nak), 64'h1);
        chk("acc0_ce",   64'(sram_ce_n), 64'(v.ece));
        chk("acc0_oe",   64'(sram_oe_n), 64'(v.eoe));
        chk("acc0_we",   64'(sram_we_n), 64'(v.ewe));
        chk("acc0_ub",   64'(sram_ub_n), 64'(v.eub));
        chk("acc0_lb",   64'(sram_lb_n), 64'(v.elb));
        chk("acc0_addr", 64'(sram_addr), 64'(v.eaddr));
        if (wr) chk("acc0_bus", 64'(sram_data), 64'(v.din));
        tick();
        chk("acc1_nak", 64'(wb_nak), 64'h1);
        chk("acc1_ce",  64'(sram_ce_n), 64'(v.ece));
        chk("acc1_we",  64'(sram_we_n), 64'(v.ewe));
        chk("acc1_oe",  64'(sram_oe_n), 64'(v.eoe));
        if (wr) chk("acc1_bus", 64'(sram_data), 64'(v.din));
        tick();
        chk("rec_nak", 64'(wb_nak), 64'h1);
        chk("rec_ce",  64'(sram_ce_n), 64'h7);
        chk("rec_oe",  64'(sram_oe_n), 64'h7);
        chk("rec_we",  64'(sram_we_n), 64'h7);
        if (wr) chk("rec_bus_hold", 64'(sram_data), 64'(v.din));
        tick();
        chk("done_nak",  64'(wb_nak), 64'h0);
        chk("done_dout", 64'(wb_dout), 64'(v.edout));
        bus_idle("done_bus_z");
    endtask

    task automatic burst(input logic rd);
        int beat = 0;
        int cyc = 0;
        int last_acc = 0;
        wb_stb  = 1'b1;
        wb_addr = 32'h100;
        wb_we   = rd ? 6'h00 : 6'h3F;
        wb_din  = pat(0);
        while (beat < 16 && cyc < 200) begin
            logic acc;
            acc = !wb_nak;
            if (acc && rd && beat > 0) chk("burst_dout", 64'(wb_dout), 64'(pat(beat - 1)));
            tick();
            cyc++;
            if (acc) begin
                if (beat > 0) chk("burst_spacing", 64'(cyc - last_acc), 64'd4);
                last_acc = cyc;
                beat++;
                wb_addr = 32'h100 + 32'(beat * 4);
                wb_din  = pat(beat);
            end
        end
        wb_stb = 1'b0;
        chk("burst_beats", 64'(beat), 64'd16);
        wait_idle();
        if (rd) chk("burst_last_dout", 64'(wb_dout), 64'(pat(15)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        //       we     addr           din                 eaddr     ce    oe    we    ub    lb    dout
        vt[0] = '{6'h00, 32'h0000_0040, 48'h0,              20'h00010, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 48'hAAAA_5555_0F0F};
        vt[1] = '{6'h3F, 32'h0000_0040, 48'h1111_2222_3333, 20'h00010, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 48'hAAAA_5555_0F0F};
        vt[2] = '{6'h00, 32'h0000_0040, 48'h0,              20'h00010, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 48'h1111_2222_3333};
        vt[3] = '{6'h04, 32'h0000_0040, 48'h9999_8877_6655, 20'h00010, 3'b101, 3'b111, 3'b101, 3'b111, 3'b101, 48'h1111_2222_3333};
        vt[4] = '{6'h00, 32'h0000_0040, 48'h0,              20'h00010, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 48'h1111_2277_3333};
        vt[5] = '{6'h21, 32'h0000_0048, 48'hABCD_1234_5678, 20'h00012, 3'b010, 3'b111, 3'b010, 3'b011, 3'b110, 48'h1111_2277_3333};
        vt[6] = '{6'h00, 32'h0000_0048, 48'h0,              20'h00012, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 48'hAB00_0000_0078};
        vt[7] = '{6'h3F, 32'h0040_0040, 48'h0123_4567_89AB, 20'h00010, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 48'hAB00_0000_0078};
        vt[8] = '{6'h00, 32'h0000_0043, 48'h0,              20'h00010, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 48'h0123_4567_89AB};

        rst_n   = 1'b0;
        wb_stb  = 1'b1;
        wb_we   = 6'h3F;
        wb_addr = 32'h40;
        wb_din  = 48'hDEAD_BEEF_CAFE;
        repeat (5) tick();
        chk("rst_nak",  64'(wb_nak), 64'h1);
        chk("rst_ce",   64'(sram_ce_n), 64'h7);
        chk("rst_oe",   64'(sram_oe_n), 64'h7);
        chk("rst_we",   64'(sram_we_n), 64'h7);
        chk("rst_ub",   64'(sram_ub_n), 64'h7);
        chk("rst_lb",   64'(sram_lb_n), 64'h7);
        chk("rst_addr", 64'(sram_addr), 64'h0);
        chk("rst_dout", 64'(wb_dout), 64'h0);
        bus_idle("rst_bus_z");

        wb_stb = 1'b0;
        rst_n  = 1'b1;
        tick();
        chk("init_to_idle_nak", 64'(wb_nak), 64'h0);
        repeat (2) tick();
        chk("idle_nostb_ce",  64'(sram_ce_n), 64'h7);
        chk("idle_nostb_nak", 64'(wb_nak), 64'h0);
        bus_idle("idle_bus_z");

        for (int i = 0; i < 9; i++) run_vec(vt[i]);

        burst(1'b0);
        burst(1'b1);

        wait_idle();
        s0 = strobes;
        wb_stb  = 1'b1;
        wb_we   = 6'h3F;
        wb_addr = 32'h44;
        wb_din  = 48'h5A5A_A5A5_3C3C;
        tick();
        wb_stb = 1'b0;
        chk("mid_rst_pre_we", 64'(sram_we_n), 64'h0);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_ce",  64'(sram_ce_n), 64'h7);
        chk("mid_rst_we",  64'(sram_we_n), 64'h7);
        chk("mid_rst_oe",  64'(sram_oe_n), 64'h7);
        chk("mid_rst_nak", 64'(wb_nak), 64'h1);
        bus_idle("mid_rst_bus_z");
        rst_n = 1'b1;
        repeat (3) tick();
        chk("mid_rst_strobes", 64'(strobes - s0), 64'd3);
        chk("mid_rst_dout",    64'(wb_dout), 64'h0);
        chk("mid_rst_nak_rel", 64'(wb_nak), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
